fetch_decode: RTL

//  Instruction fetch/decode stage directly upstream of the ALU. Fetches 64-bit

---
 rtl/fetch_decode_if.sv | 39 +++
 rtl/fetch_decode.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/fetch_decode_if.sv
// Bundle of instruction-memory fetch and ALU issue/redirect signals
// between the fetch/decode stage and its neighbours.
interface fetch_decode_if #(
    parameter int PC_W  = 64,
    parameter int REG_W = 4
);
    logic             imem_req;
    logic [PC_W-1:0]  imem_addr;
    logic             imem_ack;
    logic [63:0]      imem_rdata;
    logic             issue_valid;
    logic             issue_ready;
    logic [5:0]       instr;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] src_a;
    logic [REG_W-1:0] src_b;
    logic             highlow;
    logic [31:0]      value;
    logic             illegal;
    logic [PC_W-1:0]  pc_out;
    logic             addrch;
    logic [63:0]      naddr;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output issue_valid, instr, dst, src_a, src_b,
        output highlow, value, illegal, pc_out,
        input  issue_ready, addrch, naddr
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  issue_valid, instr, dst, src_a, src_b,
        input  highlow, value, illegal, pc_out,
        output issue_ready, addrch, naddr
    );
endinterface

// File: rtl/fetch_decode.sv
// Fetch/decode stage: req/ack instruction fetch, one-word prefetch buffer,
// registered ALU field decode and redirect with wrong-path squash.
module fetch_decode #(
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              REG_W    = 4
) (
    input logic            clock,
    input logic            reset_n,
    fetch_decode_if.master bus
);
    typedef enum logic [1:0] {EMPTY, VALID, FULL} state_t;

    typedef struct packed {
        logic [5:0]       instr;
        logic [REG_W-1:0] dst;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic             highlow;
        logic [31:0]      value;
        logic             illegal;
        logic [PC_W-1:0]  pc;
    } iss_t;

    function automatic iss_t decode(input logic [63:0] w,
                                    input logic [PC_W-1:0] pc);
        iss_t d;
        d.instr   = w[63:58];
        d.dst     = REG_W'(w[57:54]);
        d.src_a   = REG_W'(w[53:50]);
        d.src_b   = REG_W'(w[49:46]);
        d.highlow = w[45];
        d.value   = w[31:0];
        d.illegal = (w[63:58] > 6'd17);
        d.pc      = pc;
        return d;
    endfunction

    state_t          state_q;
    state_t          state_d;
    logic            kill_q;
    logic            req_q;
    logic [PC_W-1:0] addr_q;
    logic [PC_W-1:0] pc_q;
    iss_t            iss_q;
    iss_t            buf_q;
    iss_t            ack_word;
    logic            xfer;
    logic            redir;
    logic            acked;
    logic            ack_ok;
    logic            busy;
    logic            start;
    logic            ld_iss;
    logic            iss_from_buf;
    logic            ld_buf;
    logic [PC_W-1:0] fetch_src;
    logic            unused_rdata;

    assign unused_rdata = ^bus.imem_rdata[44:32];

    assign xfer      = (state_q != EMPTY) && bus.issue_ready;
    assign redir     = xfer && bus.addrch;
    assign acked     = req_q && bus.imem_ack;
    assign ack_ok    = acked && !kill_q;
    assign busy      = req_q && !bus.imem_ack;
    assign ack_word  = decode(bus.imem_rdata, addr_q);
    assign fetch_src = redir ? bus.naddr[PC_W-1:0] : pc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= EMPTY;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        ld_iss       = 1'b0;
        iss_from_buf = 1'b0;
        ld_buf       = 1'b0;
        if (redir) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (ack_ok) begin
                        state_d = VALID;
                        ld_iss  = 1'b1;
                    end
                end
                VALID: begin
                    if (xfer) begin
                        if (ack_ok) ld_iss  = 1'b1;
                        else        state_d = EMPTY;
                    end else if (ack_ok) begin
                        state_d = FULL;
                        ld_buf  = 1'b1;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        ld_iss       = 1'b1;
                        iss_from_buf = 1'b1;
                        if (ack_ok) ld_buf  = 1'b1;
                        else        state_d = VALID;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // A slot is free unless both registers will hold a word next cycle.
    assign start = !busy && (state_d != FULL);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q  <= 1'b0;
            addr_q <= '0;
            pc_q   <= RESET_PC;
            kill_q <= 1'b0;
        end else begin
            if (start) begin
                req_q  <= 1'b1;
                addr_q <= fetch_src;
                pc_q   <= fetch_src + PC_W'(1);
            end else begin
                if (acked) req_q <= 1'b0;
                if (redir) pc_q  <= bus.naddr[PC_W-1:0];
            end
            if (redir && busy) kill_q <= 1'b1;
            else if (acked)    kill_q <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iss_q <= '0;
            buf_q <= '0;
        end else begin
            if (ld_iss) iss_q <= iss_from_buf ? buf_q : ack_word;
            if (ld_buf) buf_q <= ack_word;
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.issue_valid = (state_q != EMPTY);
    assign bus.instr       = iss_q.instr;
    assign bus.dst         = iss_q.dst;
    assign bus.src_a       = iss_q.src_a;
    assign bus.src_b       = iss_q.src_b;
    assign bus.highlow     = iss_q.highlow;
    assign bus.value       = iss_q.value;
    assign bus.illegal     = iss_q.illegal;
    assign bus.pc_out      = iss_q.pc;
endmodule
